round_sequencer: RTL and testbench

Synchronous controller that runs one rock-paper-scissors round per start press. It selects the active computer player (random, Markov, reinforce), waits for the reinforce player's ready flag when needed, and latches both choices. It then evaluates the outcome, updates saturating scores, pulses the learners, and hands a redraw request to the VGA screen block. It replaces the button-clocked scoring logic in the top level with a single-clock FSM.

---
 rtl/round_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_round_sequencer.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_sequencer.sv
// Single-clock rock-paper-scissors round controller: synchronises the start key,
// picks the active computer player, scores the round and hands off a redraw.
module round_sequencer #(
    parameter int SCORE_W    = 8,
    parameter int WIN_TARGET = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start_n,
    input  logic [1:0]         mode,
    input  logic [1:0]         user,
    input  logic [1:0]         com_ra,
    input  logic [1:0]         com_m,
    input  logic [1:0]         com_re,
    input  logic               re_ready,
    input  logic               draw_done,
    output logic [1:0]         user_choice,
    output logic [1:0]         com_choice,
    output logic               uwin,
    output logic               cwin,
    output logic               equ,
    output logic [SCORE_W-1:0] user_score,
    output logic [SCORE_W-1:0] com_score,
    output logic               learn_pulse,
    output logic               draw_req,
    output logic               busy,
    output logic               match_over,
    output logic [2:0]         dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_LATCH    = 3'd2,
        S_EVAL     = 3'd3,
        S_DRAW     = 3'd4,
        S_OVER     = 3'd5
    } state_t;

    localparam logic [SCORE_W-1:0] TARGET    = SCORE_W'(WIN_TARGET);
    localparam bit                 TARGET_EN = (WIN_TARGET != 0);

    state_t     state;
    logic [1:0] mode_q;

    // Start key synchroniser and falling-edge detect.
    logic       s1, s2, s3;
    logic [1:0] fill;
    logic       armed;
    logic       start_fall;

    // The synchroniser resets to "released", so a key held through reset would
    // look like a press. armed only rises once s2 carries a real high sample.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            s3    <= 1'b1;
            fill  <= 2'd0;
            armed <= 1'b0;
        end else begin
            s1 <= start_n;
            s2 <= s1;
            s3 <= s2;
            if (fill != 2'd2) begin
                fill <= fill + 2'd1;
            end
            if (fill == 2'd2 && s2) begin
                armed <= 1'b1;
            end
        end
    end

    assign start_fall = armed & s3 & ~s2;

    // Computer choice resolution.
    logic [1:0] com_re_mapped;
    logic [1:0] com_sel;
    logic [1:0] com_resolved;

    always_comb begin
        com_re_mapped = 2'b00;
        case (com_re)
            2'b00:   com_re_mapped = 2'b01;
            2'b01:   com_re_mapped = 2'b10;
            default: com_re_mapped = 2'b00;
        endcase
    end

    always_comb begin
        com_sel = com_ra;
        case (mode_q)
            2'b01:   com_sel = com_m;
            2'b10:   com_sel = com_re_mapped;
            default: com_sel = com_ra;
        endcase
    end

    assign com_resolved = (com_sel == 2'b11) ? 2'b00 : com_sel;

    // Round outcome from the latched choices.
    function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
        return (a == 2'b00 && b == 2'b01) ||
               (a == 2'b01 && b == 2'b10) ||
               (a == 2'b10 && b == 2'b00);
    endfunction

    logic               tie;
    logic               user_wins;
    logic               com_wins;
    logic [SCORE_W-1:0] user_score_next;
    logic [SCORE_W-1:0] com_score_next;

    assign tie       = (user_choice == com_choice);
    assign user_wins = !tie && beats(user_choice, com_choice);
    assign com_wins  = !tie && beats(com_choice, user_choice);

    assign user_score_next = (&user_score) ? user_score : user_score + SCORE_W'(1);
    assign com_score_next  = (&com_score)  ? com_score  : com_score  + SCORE_W'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            mode_q      <= 2'b00;
            user_choice <= 2'b00;
            com_choice  <= 2'b00;
            uwin        <= 1'b0;
            cwin        <= 1'b0;
            equ         <= 1'b0;
            user_score  <= '0;
            com_score   <= '0;
            learn_pulse <= 1'b0;
            draw_req    <= 1'b0;
            match_over  <= 1'b0;
        end else begin
            learn_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_fall && user != 2'b11) begin
                        mode_q <= mode;
                        state  <= (mode == 2'b10) ? S_WAIT_RDY : S_LATCH;
                    end
                end
                S_WAIT_RDY: begin
                    if (re_ready) begin
                        state <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    user_choice <= user;
                    com_choice  <= com_resolved;
                    uwin        <= 1'b0;
                    cwin        <= 1'b0;
                    equ         <= 1'b0;
                    state       <= S_EVAL;
                end
                S_EVAL: begin
                    uwin <= user_wins;
                    cwin <= com_wins;
                    equ  <= tie;
                    if (user_wins) begin
                        user_score <= user_score_next;
                        if (TARGET_EN && user_score_next == TARGET) begin
                            match_over <= 1'b1;
                        end
                    end else if (com_wins) begin
                        com_score <= com_score_next;
                        if (TARGET_EN && com_score_next == TARGET) begin
                            match_over <= 1'b1;
                        end
                    end
                    learn_pulse <= 1'b1;
                    draw_req    <= 1'b1;
                    state       <= S_DRAW;
                end
                S_DRAW: begin
                    if (draw_done) begin
                        draw_req <= 1'b0;
                        state    <= match_over ? S_OVER : S_IDLE;
                    end
                end
                S_OVER: begin
                    state <= S_OVER;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: scoreboard of expected round results plus
// per-feature tasks for latency, handshakes, saturation, match end and reset.
module tb_round_sequencer;

    logic       clock;
    logic       reset;
    logic       start_n;
    logic [1:0] mode, user, com_ra, com_m, com_re;
    logic       re_ready;
    logic       draw_done;

    logic [1:0] user_choice, com_choice;
    logic       uwin, cwin, equ;
    logic [7:0] user_score, com_score;
    logic       learn_pulse, draw_req, busy, match_over;
    logic [2:0] dbg_state;

    logic [1:0] sat_user_choice, sat_com_choice;
    logic       sat_uwin, sat_cwin, sat_equ;
    logic [1:0] sat_user_score, sat_com_score;
    logic       sat_learn_pulse, sat_draw_req, sat_busy, sat_match_over;
    logic [2:0] sat_dbg_state;

    logic [1:0] tgt_user_choice, tgt_com_choice;
    logic       tgt_uwin, tgt_cwin, tgt_equ;
    logic [1:0] tgt_user_score, tgt_com_score;
    logic       tgt_learn_pulse, tgt_draw_req, tgt_busy, tgt_match_over;
    logic [2:0] tgt_dbg_state;

    round_sequencer u_dut (
        .clock(clock), .reset(reset), .start_n(start_n), .mode(mode), .user(user),
        .com_ra(com_ra), .com_m(com_m), .com_re(com_re), .re_ready(re_ready),
        .draw_done(draw_done), .user_choice(user_choice), .com_choice(com_choice),
        .uwin(uwin), .cwin(cwin), .equ(equ), .user_score(user_score),
        .com_score(com_score), .learn_pulse(learn_pulse), .draw_req(draw_req),
        .busy(busy), .match_over(match_over), .dbg_state(dbg_state)
    );

    round_sequencer #(.SCORE_W(2), .WIN_TARGET(0)) u_sat (
        .clock(clock), .reset(reset), .start_n(start_n), .mode(mode), .user(user),
        .com_ra(com_ra), .com_m(com_m), .com_re(com_re), .re_ready(re_ready),
        .draw_done(draw_done), .user_choice(sat_user_choice), .com_choice(sat_com_choice),
        .uwin(sat_uwin), .cwin(sat_cwin), .equ(sat_equ), .user_score(sat_user_score),
        .com_score(sat_com_score), .learn_pulse(sat_learn_pulse), .draw_req(sat_draw_req),
        .busy(sat_busy), .match_over(sat_match_over), .dbg_state(sat_dbg_state)
    );

    round_sequencer #(.SCORE_W(2), .WIN_TARGET(2)) u_tgt (
        .clock(clock), .reset(reset), .start_n(start_n), .mode(mode), .user(user),
        .com_ra(com_ra), .com_m(com_m), .com_re(com_re), .re_ready(re_ready),
        .draw_done(draw_done), .user_choice(tgt_user_choice), .com_choice(tgt_com_choice),
        .uwin(tgt_uwin), .cwin(tgt_cwin), .equ(tgt_equ), .user_score(tgt_user_score),
        .com_score(tgt_com_score), .learn_pulse(tgt_learn_pulse), .draw_req(tgt_draw_req),
        .busy(tgt_busy), .match_over(tgt_match_over), .dbg_state(tgt_dbg_state)
    );

    // Packed views: {user_choice, com_choice, uwin, cwin, equ, user_score, com_score}
    logic [22:0] obs;
    logic [3:0]  ctrl;
    assign obs  = {user_choice, com_choice, uwin, cwin, equ, user_score, com_score};
    assign ctrl = {learn_pulse, draw_req, busy, match_over};

    int total = 0;
    int bad   = 0;
    logic [22:0] exp_q[$];
    logic [7:0]  m_us, m_cs;

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        start_n   = 1'b1;
        mode      = 2'b00;
        user      = 2'b00;
        com_ra    = 2'b00;
        com_m     = 2'b00;
        com_re    = 2'b00;
        re_ready  = 1'b1;
        draw_done = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        m_us = 8'd0;
        m_cs = 8'd0;
        exp_q.delete();
    endtask

    // Reference model
    function automatic logic [1:0] exp_com(input logic [1:0] m, input logic [1:0] ra,
                                           input logic [1:0] cm, input logic [1:0] re);
        logic [1:0] c;
        case (m)
            2'b01: c = cm;
            2'b10: c = (re == 2'b00) ? 2'b01 : (re == 2'b01) ? 2'b10 : 2'b00;
            default: c = ra;
        endcase
        if (c == 2'b11) c = 2'b00;
        return c;
    endfunction

    function automatic logic wins(input logic [1:0] a, input logic [1:0] b);
        return (a == 2'd0 && b == 2'd1) || (a == 2'd1 && b == 2'd2) || (a == 2'd2 && b == 2'd0);
    endfunction

    // Driver: set round inputs, record the expected result, press the key.
    task automatic push_and_press(input logic [1:0] u, input logic [1:0] m,
                                  input logic [1:0] ra, input logic [1:0] cm,
                                  input logic [1:0] re);
        logic [1:0] c;
        logic uw, cw, eq;
        user   = u;
        mode   = m;
        com_ra = ra;
        com_m  = cm;
        com_re = re;
        c  = exp_com(m, ra, cm, re);
        uw = wins(u, c);
        cw = wins(c, u);
        eq = (u == c);
        if (uw && m_us != 8'hff) m_us = m_us + 8'd1;
        if (cw && m_cs != 8'hff) m_cs = m_cs + 8'd1;
        exp_q.push_back({u, c, uw, cw, eq, m_us, m_cs});
        start_n = 1'b0;
    endtask

    // Scoreboard: wait for learn_pulse, pop and compare the round result.
    task automatic collect(output int lat);
        logic [22:0] e;
        bit got;
        got = 0;
        lat = 0;
        for (int n = 1; n <= 300; n++) begin
            tick();
            if (learn_pulse === 1'b1) begin
                got = 1;
                lat = n;
                break;
            end
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL round_timeout: learn_pulse not seen in 300 cycles, state=%0d", dbg_state);
        end else if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL round_unexpected: got %h with nothing expected", obs);
        end else begin
            e = exp_q.pop_front();
            if (obs !== e) begin
                bad++;
                $display("FAIL round_result: got %h want %h", obs, e);
            end
        end
        start_n = 1'b1;
    endtask

    task automatic draw_ack();
        draw_done = 1'b1;
        tick();
        draw_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        total++;
        if (obs !== 23'd0 || ctrl !== 4'd0 || dbg_state !== 3'd0) begin
            bad++;
            $display("FAIL reset_assert: obs=%h ctrl=%b state=%0d want all 0", obs, ctrl, dbg_state);
        end
        do_reset();
        total++;
        if (obs !== 23'd0 || ctrl !== 4'd0 || dbg_state !== 3'd0) begin
            bad++;
            $display("FAIL reset_release: obs=%h ctrl=%b state=%0d want all 0", obs, ctrl, dbg_state);
        end
    endtask

    task automatic test_basic();
        int lat;
        do_reset();
        push_and_press(2'b00, 2'b00, 2'b10, 2'b00, 2'b00);
        collect(lat);
        total++;
        if (lat !== 5) begin
            bad++;
            $display("FAIL basic_latency: got %0d want 5", lat);
        end
        total++;
        if (draw_req !== 1'b1 || cwin !== 1'b1 || com_score !== 8'd1) begin
            bad++;
            $display("FAIL basic_flags: draw_req=%b cwin=%b com_score=%0d want 1 1 1", draw_req, cwin, com_score);
        end
        tick();
        total++;
        if (learn_pulse !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_pulse_width: learn_pulse=%b busy=%b want 0 1", learn_pulse, busy);
        end
        draw_ack();
        total++;
        if (busy !== 1'b0 || draw_req !== 1'b0) begin
            bad++;
            $display("FAIL basic_draw_done: busy=%b draw_req=%b want 0 0", busy, draw_req);
        end
    endtask

    task automatic test_wait_rdy();
        int lat;
        bit held;
        do_reset();
        re_ready = 1'b0;
        push_and_press(2'b01, 2'b10, 2'b00, 2'b00, 2'b01);
        for (int i = 0; i < 3; i++) tick();
        held = 1;
        for (int i = 0; i < 20; i++) begin
            if (dbg_state !== 3'd1 || learn_pulse !== 1'b0) held = 0;
            tick();
        end
        total++;
        if (!held) begin
            bad++;
            $display("FAIL wait_rdy_hold: state=%0d want 1 for 20 cycles", dbg_state);
        end
        re_ready = 1'b1;
        collect(lat);
        total++;
        if (lat !== 3) begin
            bad++;
            $display("FAIL wait_rdy_latency: got %0d want 3", lat);
        end
        draw_ack();
        // re_ready already high adds exactly one cycle
        push_and_press(2'b00, 2'b10, 2'b00, 2'b00, 2'b00);
        collect(lat);
        total++;
        if (lat !== 6) begin
            bad++;
            $display("FAIL wait_rdy_ready_latency: got %0d want 6", lat);
        end
        draw_ack();
    endtask

    task automatic test_invalid_user();
        int lat;
        bit quiet;
        do_reset();
        user    = 2'b11;
        start_n = 1'b0;
        quiet   = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (obs !== 23'd0 || ctrl !== 4'd0 || dbg_state !== 3'd0) quiet = 0;
        end
        total++;
        if (!quiet) begin
            bad++;
            $display("FAIL invalid_user: obs=%h ctrl=%b state=%0d want all 0", obs, ctrl, dbg_state);
        end
        start_n   = 1'b1;
        draw_done = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        draw_done = 1'b0;
        total++;
        if (ctrl !== 4'd0 || dbg_state !== 3'd0) begin
            bad++;
            $display("FAIL draw_done_idle: ctrl=%b state=%0d want 0 0", ctrl, dbg_state);
        end
        push_and_press(2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
        collect(lat);
        draw_ack();
    endtask

    task automatic test_back_to_back();
        int lat;
        bit quiet;
        do_reset();
        push_and_press(2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        collect(lat);
        for (int i = 0; i < 3; i++) tick();
        start_n = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        total++;
        if (dbg_state !== 3'd4 || draw_req !== 1'b1) begin
            bad++;
            $display("FAIL press_in_draw: state=%0d draw_req=%b want 4 1", dbg_state, draw_req);
        end
        draw_ack();
        quiet = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ctrl !== 4'd0 || dbg_state !== 3'd0) quiet = 0;
        end
        total++;
        if (!quiet) begin
            bad++;
            $display("FAIL press_in_draw_dropped: ctrl=%b state=%0d want 0 0", ctrl, dbg_state);
        end
        start_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        push_and_press(2'b10, 2'b01, 2'b00, 2'b10, 2'b00);
        collect(lat);
        total++;
        if (equ !== 1'b1 || user_score !== 8'd1 || com_score !== 8'd0) begin
            bad++;
            $display("FAIL equal_round: equ=%b us=%0d cs=%0d want 1 1 0", equ, user_score, com_score);
        end
        draw_ack();
    endtask

    task automatic test_random();
        int lat;
        logic [1:0] m;
        do_reset();
        for (int r = 0; r < 12; r++) begin
            m = 2'($urandom_range(0, 3));
            push_and_press(2'($urandom_range(0, 2)), m, 2'($urandom_range(0, 3)),
                           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            collect(lat);
            total++;
            if (lat !== ((m == 2'b10) ? 6 : 5)) begin
                bad++;
                $display("FAIL random_latency: round %0d mode %0d got %0d", r, m, lat);
            end
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) tick();
            draw_ack();
            total++;
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL random_idle: round %0d busy=%b want 0", r, busy);
            end
        end
    endtask

    task automatic test_saturate_target();
        int lat;
        logic [1:0] sat_exp, tgt_exp;
        do_reset();
        sat_exp = 2'd0;
        tgt_exp = 2'd0;
        for (int r = 0; r < 4; r++) begin
            push_and_press(2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
            collect(lat);
            if (sat_exp != 2'd3) sat_exp = sat_exp + 2'd1;
            if (tgt_exp != 2'd2) tgt_exp = tgt_exp + 2'd1;
            total++;
            if (sat_user_score !== sat_exp || sat_match_over !== 1'b0) begin
                bad++;
                $display("FAIL saturate: round %0d score=%0d mo=%b want %0d 0", r, sat_user_score, sat_match_over, sat_exp);
            end
            total++;
            if (tgt_user_score !== tgt_exp || tgt_match_over !== (r >= 1)) begin
                bad++;
                $display("FAIL target: round %0d score=%0d mo=%b want %0d %0d", r, tgt_user_score, tgt_match_over, tgt_exp, r >= 1);
            end
            draw_ack();
            total++;
            if (tgt_busy !== (r >= 1) || tgt_dbg_state !== ((r >= 1) ? 3'd5 : 3'd0)) begin
                bad++;
                $display("FAIL target_over: round %0d busy=%b state=%0d", r, tgt_busy, tgt_dbg_state);
            end
            for (int i = 0; i < 3; i++) tick();
        end
    endtask

    task automatic test_reset_midround();
        int lat;
        bit quiet;
        do_reset();
        user    = 2'b00;
        mode    = 2'b00;
        com_ra  = 2'b01;
        start_n = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        #1;
        total++;
        if (obs !== 23'd0 || ctrl !== 4'd0 || dbg_state !== 3'd0) begin
            bad++;
            $display("FAIL reset_in_eval: obs=%h ctrl=%b state=%0d want all 0", obs, ctrl, dbg_state);
        end
        tick();
        reset = 1'b0;
        quiet = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (obs !== 23'd0 || ctrl !== 4'd0 || dbg_state !== 3'd0) quiet = 0;
        end
        total++;
        if (!quiet) begin
            bad++;
            $display("FAIL held_key_after_reset: ctrl=%b state=%0d want 0 0", ctrl, dbg_state);
        end
        start_n = 1'b1;
        m_us = 8'd0;
        m_cs = 8'd0;
        for (int i = 0; i < 4; i++) tick();
        push_and_press(2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        collect(lat);
        total++;
        if (lat !== 5) begin
            bad++;
            $display("FAIL repress_latency: got %0d want 5", lat);
        end
        draw_ack();
    endtask

    initial begin
        do_reset();
        test_reset();
        test_basic();
        test_wait_rdy();
        test_invalid_user();
        test_back_to_back();
        test_random();
        test_saturate_target();
        test_reset_midround();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d results never produced", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
